man_setpoint_ctrl: RTL and testbench

Downstream consumer of the selector's manual-path outputs (INCR_MAN, DECR_MAN, CONF_MAN, DT_MAN).
- Edge-detects the button lines and keeps a pending setpoint that the user edits. CONF commits the pending setpoint and loads the hysteresis band.
- Runs the HEAT/COOL thermostat FSM against the measured temperature.
- Uncommitted edits are discarded after an inactivity timeout.

---
 rtl/man_setpoint_ctrl.sv | 140 ++++++++++++++
 tb/tb_man_setpoint_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/man_setpoint_ctrl.sv
// Manual setpoint editor with commit/timeout and a HEAT/COOL thermostat.
// Button lines are edge-detected; only committed T_SET/HYST drive the thermostat.
module man_setpoint_ctrl #(
  parameter int TW          = 6,
  parameter int T_MIN       = 10,
  parameter int T_MAX       = 30,
  parameter int T_DEFAULT   = 20,
  parameter int HYST_DEF    = 2,
  parameter int HYST_MAX    = 7,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          INCR_MAN,
  input  logic          DECR_MAN,
  input  logic          CONF_MAN,
  input  logic [4:0]    DT_MAN,
  input  logic [TW-1:0] T_MEAS,
  output logic [TW-1:0] T_SET,
  output logic [TW-1:0] T_PEND,
  output logic [4:0]    HYST,
  output logic          EDITING,
  output logic          CONF_ACK,
  output logic          HEAT,
  output logic          COOL
);

  localparam int TMW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMW-1:0] TO_LAST = TMW'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, EDIT} edit_t;
  typedef enum logic [1:0] {TH_OFF, TH_HEAT, TH_COOL} thermo_t;

  edit_t          edit_q;
  thermo_t        thermo_q, thermo_d;
  logic           incr_prev_q, decr_prev_q, conf_prev_q;
  logic [TMW-1:0] timer_q;
  logic [TW-1:0]  tset_q, tpend_q;
  logic [4:0]     hyst_q;
  logic           ack_q, heat_q, cool_q;

  logic          rise_inc, rise_dec, rise_conf;
  logic          step_up, step_dn, idle, timeout;
  logic [TW-1:0] base, up_val, dn_val, step_val;
  logic [4:0]    dt_clamp;

  assign rise_inc  = INCR_MAN & ~incr_prev_q;
  assign rise_dec  = DECR_MAN & ~decr_prev_q;
  assign rise_conf = CONF_MAN & ~conf_prev_q;
  // Simultaneous up/down cancels out completely.
  assign step_up   = rise_inc & ~rise_dec;
  assign step_dn   = rise_dec & ~rise_inc;
  assign idle      = (edit_q == IDLE);
  assign timeout   = !idle && (timer_q == TO_LAST);

  assign base     = idle ? tset_q : tpend_q;
  assign up_val   = (base >= TW'(T_MAX)) ? TW'(T_MAX) : base + TW'(1);
  assign dn_val   = (base <= TW'(T_MIN)) ? TW'(T_MIN) : base - TW'(1);
  assign step_val = step_up ? up_val : dn_val;

  assign dt_clamp = (DT_MAN == 5'd0) ? 5'd1 :
                    (DT_MAN > 5'(HYST_MAX)) ? 5'(HYST_MAX) : DT_MAN;

  // Two spare bits keep T_SET-HYST from wrapping below zero.
  logic signed [TW+1:0] meas_s, set_s, hyst_s, lo_s, hi_s;
  assign meas_s = signed'({2'b00, T_MEAS});
  assign set_s  = signed'({2'b00, tset_q});
  assign hyst_s = signed'({{(TW-3){1'b0}}, hyst_q});
  assign lo_s   = set_s - hyst_s;
  assign hi_s   = set_s + hyst_s;

  always_comb begin
    thermo_d = thermo_q;
    unique case (thermo_q)
      TH_OFF: begin
        if (meas_s < lo_s)      thermo_d = TH_HEAT;
        else if (meas_s > hi_s) thermo_d = TH_COOL;
      end
      TH_HEAT: if (meas_s >= set_s) thermo_d = TH_OFF;
      TH_COOL: if (meas_s <= set_s) thermo_d = TH_OFF;
      default: thermo_d = TH_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edit_q      <= IDLE;
      thermo_q    <= TH_OFF;
      incr_prev_q <= 1'b0;
      decr_prev_q <= 1'b0;
      conf_prev_q <= 1'b0;
      timer_q     <= '0;
      tset_q      <= TW'(T_DEFAULT);
      tpend_q     <= TW'(T_DEFAULT);
      hyst_q      <= 5'(HYST_DEF);
      ack_q       <= 1'b0;
      heat_q      <= 1'b0;
      cool_q      <= 1'b0;
    end else begin
      incr_prev_q <= INCR_MAN;
      decr_prev_q <= DECR_MAN;
      conf_prev_q <= CONF_MAN;
      ack_q       <= rise_conf;
      thermo_q    <= thermo_d;
      heat_q      <= (thermo_d == TH_HEAT);
      cool_q      <= (thermo_d == TH_COOL);
      if (rise_conf) begin
        hyst_q  <= dt_clamp;
        timer_q <= '0;
        edit_q  <= IDLE;
        if (!idle) tset_q <= tpend_q;
      end else if (idle) begin
        timer_q <= '0;
        tpend_q <= tset_q;
        if (step_up || step_dn) begin
          tpend_q <= step_val;
          edit_q  <= EDIT;
        end
      end else if (timeout) begin
        tpend_q <= tset_q;
        timer_q <= '0;
        edit_q  <= IDLE;
      end else if (step_up || step_dn) begin
        tpend_q <= step_val;
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + TMW'(1);
      end
    end
  end

  assign T_SET    = tset_q;
  assign T_PEND   = tpend_q;
  assign HYST     = hyst_q;
  assign EDITING  = (edit_q == EDIT);
  assign CONF_ACK = ack_q;
  assign HEAT     = heat_q;
  assign COOL     = cool_q;

endmodule

// File: tb/tb_man_setpoint_ctrl.sv
// Bench for man_setpoint_ctrl: directed plan steps plus random traffic
// checked cycle by cycle against an integer reference model.
module tb_man_setpoint_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       INCR_MAN = 1'b0, DECR_MAN = 1'b0, CONF_MAN = 1'b0;
  logic [4:0] DT_MAN = '0;
  logic [5:0] T_MEAS = 6'd20;
  logic [5:0] T_SET, T_PEND;
  logic [4:0] HYST;
  logic       EDITING, CONF_ACK, HEAT, COOL;

  man_setpoint_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .INCR_MAN(INCR_MAN), .DECR_MAN(DECR_MAN), .CONF_MAN(CONF_MAN),
    .DT_MAN(DT_MAN), .T_MEAS(T_MEAS),
    .T_SET(T_SET), .T_PEND(T_PEND), .HYST(HYST),
    .EDITING(EDITING), .CONF_ACK(CONF_ACK), .HEAT(HEAT), .COOL(COOL)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  // Reference model: plain integers; mode 0=off 1=heat 2=cool.
  int m_set, m_pend, m_hyst, m_idle, m_mode;
  bit m_edit, m_ack, p_i, p_d, p_c;
  int meas_cur = 20;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_reset();
    m_set = 20; m_pend = 20; m_hyst = 2; m_idle = 0; m_mode = 0;
    m_edit = 0; m_ack = 0; p_i = 0; p_d = 0; p_c = 0;
  endtask

  task automatic model_step(input bit inc, dec, conf, input int dt, meas);
    bit ri, rd, rc;
    int delta;
    ri = inc && !p_i; rd = dec && !p_d; rc = conf && !p_c;
    p_i = inc; p_d = dec; p_c = conf;
    delta = (ri && !rd) ? 1 : (rd && !ri) ? -1 : 0;
    case (m_mode)
      0: if (meas < m_set - m_hyst) m_mode = 1;
         else if (meas > m_set + m_hyst) m_mode = 2;
      1: if (meas >= m_set) m_mode = 0;
      default: if (meas <= m_set) m_mode = 0;
    endcase
    m_ack = rc;
    if (rc) begin
      m_hyst = (dt == 0) ? 1 : clampi(dt, 1, 7);
      if (m_edit) m_set = m_pend;
      m_edit = 0; m_idle = 0;
    end else if (!m_edit) begin
      m_pend = m_set;
      if (delta != 0) begin
        m_pend = clampi(m_set + delta, 10, 30);
        m_edit = 1; m_idle = 0;
      end
    end else if (m_idle == TO - 1) begin
      m_pend = m_set; m_edit = 0; m_idle = 0;
    end else if (delta != 0) begin
      m_pend = clampi(m_pend + delta, 10, 30);
      m_idle = 0;
    end else begin
      m_idle++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("m_T_SET", 32'(T_SET), m_set);
    chk("m_T_PEND", 32'(T_PEND), m_pend);
    chk("m_HYST", 32'(HYST), m_hyst);
    chk("m_EDITING", 32'(EDITING), 32'(m_edit));
    chk("m_CONF_ACK", 32'(CONF_ACK), 32'(m_ack));
    chk("m_HEAT", 32'(HEAT), 32'(m_mode == 1));
    chk("m_COOL", 32'(COOL), 32'(m_mode == 2));
  endtask

  task automatic cyc(input bit inc, dec, conf, input int dt, meas);
    INCR_MAN = inc; DECR_MAN = dec; CONF_MAN = conf;
    DT_MAN = dt[4:0]; T_MEAS = meas[5:0]; meas_cur = meas;
    @(posedge clk);
    model_step(inc, dec, conf, dt, meas);
    #1;
    check_all();
  endtask

  // kind: 0=INCR 1=DECR 2=CONF; one press cycle then one release cycle
  task automatic pulse(input int kind, input int dt);
    cyc(kind == 0, kind == 1, kind == 2, dt, meas_cur);
    cyc(0, 0, 0, dt, meas_cur);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_T_SET"}, 32'(T_SET), 20);
    chk({tag, "_T_PEND"}, 32'(T_PEND), 20);
    chk({tag, "_HYST"}, 32'(HYST), 2);
    chk({tag, "_EDITING"}, 32'(EDITING), 0);
    chk({tag, "_ACK"}, 32'(CONF_ACK), 0);
    chk({tag, "_HEAT"}, 32'(HEAT), 0);
    chk({tag, "_COOL"}, 32'(COOL), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sat_up[5];
    int sat_dn[5];
    int th_meas[11];
    int th_heat[11];
    int th_cool[11];
    sat_up = '{29, 30, 30, 30, 30};
    sat_dn = '{11, 10, 10, 10, 10};
    th_meas = '{18, 17, 19, 20, 22, 23, 20, 17, 25, 25, 20};
    th_heat = '{0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    th_cool = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    model_reset();

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);

    // 1: held INCR counts once; held CONF acks once
    repeat (3) cyc(1, 0, 0, 0, 20);
    chk("t1_pend", 32'(T_PEND), 21);
    chk("t1_set", 32'(T_SET), 20);
    chk("t1_edit", 32'(EDITING), 1);
    cyc(0, 0, 1, 9, 20);
    chk("t1_commit", 32'(T_SET), 21);
    chk("t1_hyst", 32'(HYST), 7);
    chk("t1_ack1", 32'(CONF_ACK), 1);
    chk("t1_edit0", 32'(EDITING), 0);
    cyc(0, 0, 1, 9, 20);
    chk("t1_ack2", 32'(CONF_ACK), 0);
    cyc(0, 0, 0, 9, 20);

    // 2: saturation at both bounds
    repeat (7) pulse(0, 2);
    pulse(2, 2);
    chk("t2_set28", 32'(T_SET), 28);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 2, 20);
      chk("t2_sat_up", 32'(T_PEND), sat_up[i]);
      cyc(0, 0, 0, 2, 20);
    end
    pulse(2, 2);
    chk("t2_set30", 32'(T_SET), 30);
    repeat (18) pulse(1, 2);
    pulse(2, 2);
    chk("t2_set12", 32'(T_SET), 12);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 2, 20);
      chk("t2_sat_dn", 32'(T_PEND), sat_dn[i]);
      cyc(0, 0, 0, 2, 20);
    end
    pulse(2, 2);
    chk("t2_set10", 32'(T_SET), 10);
    repeat (10) pulse(0, 2);
    pulse(2, 2);
    chk("t2_set20", 32'(T_SET), 20);

    // 3: timeout exactly TO cycles after the last accepted press
    cyc(0, 1, 0, 2, 20);
    chk("t3_pend19", 32'(T_PEND), 19);
    for (int k = 1; k <= TO; k++) begin
      cyc(0, 0, 0, 2, 20);
      chk("t3_edit", 32'(EDITING), (k < TO) ? 1 : 0);
      chk("t3_ack", 32'(CONF_ACK), 0);
    end
    chk("t3_pend_back", 32'(T_PEND), 20);
    cyc(0, 1, 0, 2, 20);
    for (int k = 1; k < 10; k++) cyc(0, 0, 0, 2, 20);
    cyc(0, 1, 0, 2, 20);
    chk("t3_pend18", 32'(T_PEND), 18);
    for (int k = 1; k <= TO; k++) begin
      cyc(0, 0, 0, 2, 20);
      chk("t3_edit_re", 32'(EDITING), (k < TO) ? 1 : 0);
    end
    chk("t3_pend_re", 32'(T_PEND), 20);

    // 4: simultaneous presses and CONF priority
    pulse(0, 2);
    pulse(0, 2);
    cyc(1, 1, 0, 2, 20);
    chk("t4_both", 32'(T_PEND), 22);
    cyc(0, 0, 0, 2, 20);
    cyc(1, 0, 1, 2, 20);
    chk("t4_prio", 32'(T_SET), 22);
    chk("t4_prio_ack", 32'(CONF_ACK), 1);
    cyc(0, 0, 0, 2, 20);
    cyc(0, 0, 1, 0, 20);
    chk("t4_hyst1", 32'(HYST), 1);
    chk("t4_idle_set", 32'(T_SET), 22);
    chk("t4_idle_ack", 32'(CONF_ACK), 1);
    cyc(0, 0, 0, 0, 20);
    pulse(1, 2);
    pulse(1, 2);
    pulse(2, 2);
    repeat (3) cyc(0, 0, 0, 2, 20);

    // 5: thermostat hysteresis, T_SET=20 HYST=2
    for (int i = 0; i < 11; i++) begin
      cyc(0, 0, 0, 2, th_meas[i]);
      chk("t5_heat", 32'(HEAT), th_heat[i]);
      chk("t5_cool", 32'(COOL), th_cool[i]);
    end

    // random traffic at varying press rates
    for (int seg = 0; seg < 4; seg++) begin
      int rate;
      rate = (seg % 2 == 0) ? 3 : 40;
      for (int n = 0; n < 100; n++) begin
        cyc($urandom_range(0, rate) == 0, $urandom_range(0, rate) == 0,
            $urandom_range(0, 4 * rate) == 0, $urandom_range(0, 31),
            $urandom_range(0, 45));
      end
    end

    // 6: asynchronous reset while editing and heating
    repeat (3) cyc(0, 0, 0, 0, 0);
    pulse(0, 0);
    chk("t6_heat", 32'(HEAT), 1);
    chk("t6_edit", 32'(EDITING), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_vals("t6_async");
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 0, 0, 0, 20);
    chk("t6_pend21", 32'(T_PEND), 21);
    cyc(0, 0, 0, 0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
